// File: rtl/dequant_zigzag_writer.sv
// Dequantizes zigzag-ordered coefficients and writes them to the pre-IDCT SRAM region in raster order.
// Optional macro DEQUANT_SATURATE_EN: saturate the 22-bit result to 16 bits instead of truncating.
module dequant_zigzag_writer #(
  parameter logic [17:0] PRE_IDCT_BASE = 18'd76800,
  parameter int          BLOCK_ROWS    = 30
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic        Q_select,
  input  logic        coeff_valid,
  input  logic [15:0] coeff_data,
  output logic        coeff_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BLOCK_END, S_DONE} state_t;

  localparam logic [7:0] ROW_LAST = 8'(BLOCK_ROWS - 1);

  // Raster position (row*8+col) of each zigzag index.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [2:0] shift_for(input logic [3:0] diag, input logic qsel);
    logic [2:0] s;
    if (!qsel) begin
      case (diag)
        4'd0:    s = 3'd3;
        4'd1:    s = 3'd2;
        4'd2:    s = 3'd3;
        4'd3:    s = 3'd3;
        4'd4:    s = 3'd4;
        4'd5:    s = 3'd4;
        4'd6:    s = 3'd5;
        4'd7:    s = 3'd5;
        default: s = 3'd6;
      endcase
    end else begin
      case (diag)
        4'd0:    s = 3'd3;
        4'd1:    s = 3'd1;
        4'd2:    s = 3'd1;
        4'd3:    s = 3'd1;
        4'd4:    s = 3'd2;
        4'd5:    s = 3'd2;
        4'd6:    s = 3'd3;
        4'd7:    s = 3'd3;
        default: s = 3'd4;
      endcase
    end
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;
  logic [5:0]  col_q, col_d;
  logic [7:0]  brow_q, brow_d;
  logic [1:0]  plane_q, plane_d;
  logic        qsel_q, qsel_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_n_q, we_n_d;

  logic [5:0]  zz_pos;
  logic [2:0]  zz_row, zz_col;
  logic [2:0]  shift_amt;
  logic [17:0] plane_base, stride, line, addr_calc;
  logic [5:0]  col_last;
  logic [15:0] deq16;

  assign zz_pos    = ZIGZAG[k_q];
  assign zz_row    = zz_pos[5:3];
  assign zz_col    = zz_pos[2:0];
  assign shift_amt = shift_for({1'b0, zz_row} + {1'b0, zz_col}, qsel_q);

  always_comb begin
    plane_base = PRE_IDCT_BASE;
    stride     = 18'd320;
    col_last   = 6'd39;
    case (plane_q)
      2'd0: begin
        plane_base = PRE_IDCT_BASE;
        stride     = 18'd320;
        col_last   = 6'd39;
      end
      2'd1: begin
        plane_base = PRE_IDCT_BASE + 18'd76800;
        stride     = 18'd160;
        col_last   = 6'd19;
      end
      default: begin
        plane_base = PRE_IDCT_BASE + 18'd115200;
        stride     = 18'd160;
        col_last   = 6'd19;
      end
    endcase
  end

  assign line      = 18'({brow_q, 3'b000}) + 18'(zz_row);
  assign addr_calc = plane_base + line * stride + 18'({col_q, 3'b000}) + 18'(zz_col);

`ifdef DEQUANT_SATURATE_EN
  logic signed [21:0] wide;
  assign wide  = $signed({{6{coeff_data[15]}}, coeff_data}) <<< shift_amt;
  assign deq16 = (wide > 22'sd32767)  ? 16'h7FFF :
                 (wide < -22'sd32768) ? 16'h8000 : wide[15:0];
`else
  // The low 16 bits of the 22-bit shifted value equal a plain 16-bit shift.
  assign deq16 = coeff_data << shift_amt;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    col_d   = col_q;
    brow_d  = brow_q;
    plane_d = plane_q;
    qsel_d  = qsel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_n_d  = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (Enable) begin
          state_d = S_RUN;
          qsel_d  = Q_select;
          k_d     = 6'd0;
          col_d   = 6'd0;
          brow_d  = 8'd0;
          plane_d = 2'd0;
        end
      end
      S_RUN: begin
        if (coeff_valid) begin
          we_n_d = 1'b0;
          addr_d = addr_calc;
          data_d = deq16;
          k_d    = k_q + 6'd1;
          if (k_q == 6'd63) state_d = S_BLOCK_END;
        end
      end
      S_BLOCK_END: begin
        state_d = S_RUN;
        if (col_q == col_last) begin
          col_d = 6'd0;
          if (brow_q == ROW_LAST) begin
            brow_d = 8'd0;
            if (plane_q == 2'd2) begin
              plane_d = 2'd0;
              state_d = S_DONE;
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end else begin
            brow_d = brow_q + 8'd1;
          end
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      k_q     <= 6'd0;
      col_q   <= 6'd0;
      brow_q  <= 8'd0;
      plane_q <= 2'd0;
      qsel_q  <= 1'b0;
      addr_q  <= 18'd0;
      data_q  <= 16'd0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      brow_q  <= brow_d;
      plane_q <= plane_d;
      qsel_q  <= qsel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_n_q  <= we_n_d;
    end
  end

  assign coeff_ready     = (state_q == S_RUN);
  assign Done            = (state_q == S_DONE);
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = data_q;
  assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_dequant_zigzag_writer.sv
// Randomized bench for dequant_zigzag_writer against a behavioural block/zigzag model.
// Uses BLOCK_ROWS=2 so complete runs stay short.
module tb_dequant_zigzag_writer;

  localparam int BR    = 2;
  localparam int TOTAL = 80 * BR;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic        Q_select = 1'b0;
  logic        coeff_valid = 1'b0;
  logic [15:0] coeff_data = 16'd0;
  logic        coeff_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        Done;

  dequant_zigzag_writer #(.PRE_IDCT_BASE(18'd76800), .BLOCK_ROWS(BR)) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Q_select(Q_select),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Done(Done)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Zigzag order built by walking anti-diagonals, alternating direction.
  int zz_r[64];
  int zz_c[64];
  int q0_tab[9] = '{3, 2, 3, 3, 4, 4, 5, 5, 6};
  int q1_tab[9] = '{3, 1, 1, 1, 2, 2, 3, 3, 4};

  // Model state
  bit m_active, m_bubble, m_done, m_q;
  int m_k, m_blk;
  int n_writes;

  function automatic int exp_addr(input int blk, input int k);
    int base, stride, bc, br, rel;
    if (blk < 40 * BR) begin
      base = 76800; stride = 320; rel = blk; bc = rel % 40; br = rel / 40;
    end else if (blk < 60 * BR) begin
      base = 153600; stride = 160; rel = blk - 40 * BR; bc = rel % 20; br = rel / 20;
    end else begin
      base = 192000; stride = 160; rel = blk - 60 * BR; bc = rel % 20; br = rel / 20;
    end
    return base + (8 * br + zz_r[k]) * stride + 8 * bc + zz_c[k];
  endfunction

  function automatic logic [15:0] exp_data(input logic [15:0] d, input bit q, input int k);
    int diag, s, v;
    logic [31:0] vv;
    diag = zz_r[k] + zz_c[k];
    if (diag > 8) diag = 8;
    s = q ? q1_tab[diag] : q0_tab[diag];
    v = int'($signed(d)) * (1 << s);
`ifdef DEQUANT_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    vv = v;
    return vv[15:0];
  endfunction

  // One clock cycle: apply inputs, check combinational outputs mid-cycle,
  // then check the registered write after the edge and advance the model.
  task automatic step(input bit en, input bit v, input logic [15:0] d, input bit qs);
    bit exp_ready, xfer, start;
    int ea;
    logic [15:0] ed;
    Enable = en; coeff_valid = v; coeff_data = d; Q_select = qs;
    @(negedge Clock);
    exp_ready = m_active && !m_bubble;
    check_value("coeff_ready", coeff_ready, exp_ready);
    check_value("Done", Done, m_done);
    xfer  = v && exp_ready;
    start = en && !m_active && !m_bubble && !m_done;
    ea = 0; ed = 16'd0;
    if (xfer) begin
      ea = exp_addr(m_blk, m_k);
      ed = exp_data(d, m_q, m_k);
    end
    @(posedge Clock);
    #1;
    check_value("SRAM_we_n", SRAM_we_n, !xfer);
    if (xfer) begin
      check_value("SRAM_address", SRAM_address, ea);
      check_value("SRAM_write_data", SRAM_write_data, ed);
      n_writes++;
      $display("write blk=%0d k=%0d addr=%0d data=0x%04h", m_blk, m_k, ea, ed);
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_bubble) begin
      m_bubble = 0;
      if (m_blk == TOTAL) begin
        m_active = 0;
        m_done   = 1;
      end
    end else if (xfer) begin
      m_k++;
      if (m_k == 64) begin
        m_k = 0; m_blk++; m_bubble = 1;
      end
    end else if (start) begin
      m_active = 1; m_k = 0; m_blk = 0; m_q = qs;
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_bubble = 0; m_done = 0; m_k = 0; m_blk = 0;
  endtask

  task automatic apply_reset();
    Resetn = 1'b0;
    Enable = 1'b0; coeff_valid = 1'b0;
    #2;
    check_value("rst_ready", coeff_ready, 1'b0);
    check_value("rst_we_n", SRAM_we_n, 1'b1);
    check_value("rst_addr", SRAM_address, 18'd0);
    check_value("rst_data", SRAM_write_data, 16'd0);
    check_value("rst_done", Done, 1'b0);
    model_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  // vmode: 0 valid held, 1 alternating, 2 random. pat: directed data for early blocks.
  // Returns early (leaving the run in progress) when block stop_blk reaches k=stop_k.
  task automatic run(input bit q, input int vmode, input int pat, input int stop_blk, input int stop_k);
    int cyc;
    bit v, en;
    logic [15:0] d;
    int seen_done;
    seen_done = 0;
    step(1'b1, 1'b0, 16'd0, q);
    cyc = 0;
    while ((m_active || m_bubble || m_done) && cyc < 40000) begin
      if (m_blk == stop_blk && m_k == stop_k) return;
      case (vmode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d = 16'($signed(10'($urandom)));
      if (pat == 1 && m_blk == 0) d = 16'd1;
      if (pat == 1 && m_blk == 1 && m_k == 63) d = 16'd1000;
      if (pat == 2 && m_blk == 0 && m_k == 0) d = 16'hFFFF;
      if (pat == 2 && m_blk == 0 && m_k == 1) d = 16'hFFFD;
      en = ($urandom_range(0, 15) == 0);
      if (m_done) seen_done++;
      step(en, v, d, 1'($urandom));
      cyc++;
    end
    check_value("run_finished", (m_active || m_bubble || m_done), 1'b0);
    check_value("done_pulses", seen_done, 1);
  endtask

  initial begin
    int k;
    k = 0;
    for (int dg = 0; dg < 15; dg++) begin
      if (dg % 2 == 0) begin
        for (int r = (dg < 7 ? dg : 7); r >= (dg > 7 ? dg - 7 : 0); r--) begin
          zz_r[k] = r; zz_c[k] = dg - r; k++;
        end
      end else begin
        for (int r = (dg > 7 ? dg - 7 : 0); r <= (dg < 7 ? dg : 7); r++) begin
          zz_r[k] = r; zz_c[k] = dg - r; k++;
        end
      end
    end
    n_writes = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    apply_reset();
    check_value("zz_k63_addr", exp_addr(0, 63), 79047);
    // Q0, first block all ones, random valid, whole frame
    run(1'b0, 2, 1, -1, -1);
    // Q1 with directed negative coefficients, then reset in the middle of block 5
    run(1'b1, 1, 2, 5, 20);
    #3;
    apply_reset();
    // Restart after reset must begin at the first Y block
    run(1'b1, 0, 0, -1, -1);
    check_value("write_count", n_writes, 64 * TOTAL * 2 + 64 * 5 + 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
